// File: rtl/alu_pin_pkg.sv
// Shared types and constants for the tt_um_8bitALU pin driver: FSM states,
// opcode encodings and the layout of the opcode frame byte.
package alu_pin_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_A,
    ST_SEND_B,
    ST_SEND_OP,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_NOT_A = 3'd5;
  localparam logic [2:0] OP_SHL   = 3'd6;
  localparam logic [2:0] OP_SHR   = 3'd7;

  localparam int EXEC_BIT  = 7;
  localparam int FRAME_LEN = 3;

  // Third frame byte: EXEC strobe on IN7, opcode in the low bits.
  function automatic logic [7:0] op_byte(input logic [2:0] op);
    logic [7:0] b;
    b           = '0;
    b[EXEC_BIT] = 1'b1;
    b[2:0]      = op;
    return b;
  endfunction

endpackage

// File: rtl/alu_pin_driver.sv
// Serialises A, B, opcode onto IN0..IN7, samples OUT0..OUT7 RESULT_LAT cycles after
// the opcode byte; result held on rsp_* until rsp_ready, request accepted only in IDLE.
module alu_pin_driver
  import alu_pin_pkg::*;
#(
  parameter int RESULT_LAT   = 2,
  parameter bit ZERO_FLAG_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [2:0] req_op,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_zero,
  output logic       IN0,
  output logic       IN1,
  output logic       IN2,
  output logic       IN3,
  output logic       IN4,
  output logic       IN5,
  output logic       IN6,
  output logic       IN7,
  input  logic       OUT0,
  input  logic       OUT1,
  input  logic       OUT2,
  input  logic       OUT3,
  input  logic       OUT4,
  input  logic       OUT5,
  input  logic       OUT6,
  input  logic       OUT7
);

  // Counter enters WAIT one cycle after the opcode byte, so it starts at LAT-1.
  localparam logic [3:0] LAT_LOAD = 4'(RESULT_LAT - 1);

  state_t     state;
  logic [7:0] in_bus;
  logic [7:0] out_bus;
  logic [7:0] b_q;
  logic [2:0] op_q;
  logic [3:0] cnt;

  assign {IN7, IN6, IN5, IN4, IN3, IN2, IN1, IN0} = in_bus;
  assign out_bus = {OUT7, OUT6, OUT5, OUT4, OUT3, OUT2, OUT1, OUT0};
  assign req_ready = (state == ST_IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      in_bus     <= 8'h00;
      b_q        <= 8'h00;
      op_q       <= 3'd0;
      cnt        <= 4'd0;
      rsp_valid  <= 1'b0;
      rsp_result <= 8'h00;
      rsp_zero   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            b_q    <= req_b;
            op_q   <= req_op;
            in_bus <= req_a;
            state  <= ST_SEND_A;
          end
        end
        ST_SEND_A: begin
          in_bus <= b_q;
          state  <= ST_SEND_B;
        end
        ST_SEND_B: begin
          in_bus <= op_byte(op_q);
          state  <= ST_SEND_OP;
        end
        ST_SEND_OP: begin
          in_bus <= 8'h00;
          cnt    <= LAT_LOAD;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            rsp_result <= out_bus;
            rsp_zero   <= ZERO_FLAG_EN && (out_bus == 8'h00);
            rsp_valid  <= 1'b1;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pin_driver.sv
// Directed bench for alu_pin_driver: a RESULT_LAT=2 instance for the main scenarios
// and a RESULT_LAT=1 instance for the short-latency sample point.
module tb_alu_pin_driver;
  import alu_pin_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, rsp_ready;
  logic [7:0] req_a, req_b;
  logic [2:0] req_op;
  logic       req_ready, rsp_valid, rsp_zero;
  logic [7:0] rsp_result;
  wire  [7:0] in_bus;
  logic [7:0] out_bus;

  logic       req_valid1, rsp_ready1;
  logic [7:0] req_a1, req_b1;
  logic [2:0] req_op1;
  logic       req_ready1, rsp_valid1, rsp_zero1;
  logic [7:0] rsp_result1;
  wire  [7:0] in_bus1;
  logic [7:0] out_bus1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_pin_driver #(.RESULT_LAT(2), .ZERO_FLAG_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .IN0(in_bus[0]), .IN1(in_bus[1]), .IN2(in_bus[2]), .IN3(in_bus[3]),
    .IN4(in_bus[4]), .IN5(in_bus[5]), .IN6(in_bus[6]), .IN7(in_bus[7]),
    .OUT0(out_bus[0]), .OUT1(out_bus[1]), .OUT2(out_bus[2]), .OUT3(out_bus[3]),
    .OUT4(out_bus[4]), .OUT5(out_bus[5]), .OUT6(out_bus[6]), .OUT7(out_bus[7])
  );

  alu_pin_driver #(.RESULT_LAT(1), .ZERO_FLAG_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_a(req_a1), .req_b(req_b1), .req_op(req_op1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_result(rsp_result1), .rsp_zero(rsp_zero1),
    .IN0(in_bus1[0]), .IN1(in_bus1[1]), .IN2(in_bus1[2]), .IN3(in_bus1[3]),
    .IN4(in_bus1[4]), .IN5(in_bus1[5]), .IN6(in_bus1[6]), .IN7(in_bus1[7]),
    .OUT0(out_bus1[0]), .OUT1(out_bus1[1]), .OUT2(out_bus1[2]), .OUT3(out_bus1[3]),
    .OUT4(out_bus1[4]), .OUT5(out_bus1[5]), .OUT6(out_bus1[6]), .OUT7(out_bus1[7])
  );

  task automatic test_reset();
    @(negedge clk);
    checks++; if (in_bus !== 8'h00) begin errors++; $display("FAIL reset_in: got %h want 00", in_bus); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_result !== 8'h00 || rsp_zero !== 1'b0) begin errors++; $display("FAIL reset_rsp: got %h/%b want 00/0", rsp_result, rsp_zero); end
    checks++; if (rsp_valid1 !== 1'b0 || in_bus1 !== 8'h00) begin errors++; $display("FAIL reset_lat1: got %b/%h want 0/00", rsp_valid1, in_bus1); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
  endtask

  // Full frame with rsp_ready already high; OUT holds the result only in the sample cycle.
  task automatic test_frame(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                            input logic [7:0] exp, input logic exp_zero);
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1; rsp_ready = 1'b1; out_bus = ~exp;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL frame_idle_ready: got %b want 1", req_ready); end
    @(negedge clk);  // cycle 1
    req_valid = 1'b0; req_a = ~a; req_b = ~b; req_op = ~op;
    checks++; if (in_bus !== a) begin errors++; $display("FAIL frame_a: got %h want %h", in_bus, a); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL frame_busy_ready: got %b want 0", req_ready); end
    @(negedge clk);  // cycle 2
    checks++; if (in_bus !== b) begin errors++; $display("FAIL frame_b: got %h want %h", in_bus, b); end
    @(negedge clk);  // cycle 3
    checks++; if (in_bus !== {1'b1, 4'b0000, op}) begin errors++; $display("FAIL frame_op: got %h want %h", in_bus, {1'b1, 4'b0000, op}); end
    @(negedge clk);  // cycle 4
    checks++; if (in_bus !== 8'h00 || rsp_valid !== 1'b0) begin errors++; $display("FAIL frame_wait1: got %h/%b want 00/0", in_bus, rsp_valid); end
    @(negedge clk);  // cycle 5: sampled at the edge ending this cycle
    out_bus = exp;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL frame_early_valid: got %b want 0", rsp_valid); end
    @(negedge clk);  // cycle 6
    out_bus = ~exp;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL frame_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_result !== exp) begin errors++; $display("FAIL frame_result: got %h want %h", rsp_result, exp); end
    checks++; if (rsp_zero !== exp_zero) begin errors++; $display("FAIL frame_zero: got %b want %b", rsp_zero, exp_zero); end
    @(negedge clk);  // cycle 7
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL frame_done: got valid=%b ready=%b want 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_back_to_back();
    req_a = 8'h3C; req_b = 8'h05; req_op = OP_ADD; req_valid = 1'b1; rsp_ready = 1'b1; out_bus = 8'hBE;
    @(negedge clk);  // cycle 1
    req_a = 8'h11; req_b = 8'h22; req_op = OP_AND;
    checks++; if (in_bus !== 8'h3C) begin errors++; $display("FAIL b2b_a1: got %h want 3c", in_bus); end
    for (int c = 2; c <= 7; c++) begin
      @(negedge clk);
      if (c == 5) out_bus = 8'h41;
      if (c == 6) out_bus = 8'hBE;
      if (c >= 4) begin
        checks++; if (in_bus !== 8'h00) begin errors++; $display("FAIL b2b_idle_bus c%0d: got %h want 00", c, in_bus); end
      end
      if (c == 6) begin
        checks++; if (rsp_result !== 8'h41) begin errors++; $display("FAIL b2b_result1: got %h want 41", rsp_result); end
      end
      checks++; if (req_ready !== (c == 7)) begin errors++; $display("FAIL b2b_ready c%0d: got %b want %b", c, req_ready, (c == 7)); end
    end
    @(negedge clk);  // cycle 8
    req_valid = 1'b0;
    checks++; if (in_bus !== 8'h11) begin errors++; $display("FAIL b2b_a2: got %h want 11", in_bus); end
    for (int c = 9; c <= 13; c++) begin
      @(negedge clk);
      if (c == 12) out_bus = 8'h00;
      if (c == 13) out_bus = 8'hBE;
    end
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 8'h00 || rsp_zero !== 1'b1) begin
      errors++; $display("FAIL b2b_rsp2: got %b/%h/%b want 1/00/1", rsp_valid, rsp_result, rsp_zero);
    end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_end_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_stall();
    req_a = 8'h3C; req_b = 8'h05; req_op = OP_ADD; req_valid = 1'b1; rsp_ready = 1'b0; out_bus = 8'hBE;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (c == 5) out_bus = 8'h41;
      if (c == 6) out_bus = 8'hBE;
    end
    for (int i = 0; i < 10; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_result !== 8'h41) begin errors++; $display("FAIL stall_hold %0d: got %b/%h want 1/41", i, rsp_valid, rsp_result); end
      checks++; if (in_bus !== 8'h00 || req_ready !== 1'b0) begin errors++; $display("FAIL stall_bus %0d: got %h/%b want 00/0", i, in_bus, req_ready); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got %b/%b want 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_reset_in_wait();
    req_a = 8'h3C; req_b = 8'h05; req_op = OP_ADD; req_valid = 1'b1; rsp_ready = 1'b1; out_bus = 8'h41;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    checks++; if (in_bus !== 8'h80) begin errors++; $display("FAIL rst_pre_op: got %h want 80", in_bus); end
    @(negedge clk);  // cycle 4, in WAIT
    rst = 1'b1;
    #1;
    checks++; if (in_bus !== 8'h00 || req_ready !== 1'b0) begin errors++; $display("FAIL rst_async_bus: got %h/%b want 00/0", in_bus, req_ready); end
    checks++; if (rsp_result !== 8'h00 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_async_rsp: got %h/%b want 00/0", rsp_result, rsp_valid); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || in_bus !== 8'h00) begin errors++; $display("FAIL rst_no_resume %0d: got %b/%h want 0/00", i, rsp_valid, in_bus); end
    end
    test_frame(8'h0F, 8'hF0, OP_OR, 8'hFF, 1'b0);
  endtask

  task automatic test_lat1();
    req_a1 = 8'h81; req_b1 = 8'h00; req_op1 = OP_SHL; req_valid1 = 1'b1; rsp_ready1 = 1'b1; out_bus1 = 8'hFD;
    checks++; if (req_ready1 !== 1'b1) begin errors++; $display("FAIL lat1_ready: got %b want 1", req_ready1); end
    @(negedge clk);  // cycle 1
    req_valid1 = 1'b0;
    checks++; if (in_bus1 !== 8'h81) begin errors++; $display("FAIL lat1_a: got %h want 81", in_bus1); end
    @(negedge clk);  // cycle 2
    @(negedge clk);  // cycle 3
    checks++; if (in_bus1 !== 8'h86) begin errors++; $display("FAIL lat1_op: got %h want 86", in_bus1); end
    @(negedge clk);  // cycle 4: sampled at the edge ending this cycle
    out_bus1 = 8'h02;
    checks++; if (rsp_valid1 !== 1'b0) begin errors++; $display("FAIL lat1_early: got %b want 0", rsp_valid1); end
    @(negedge clk);  // cycle 5
    out_bus1 = 8'hFD;
    checks++; if (rsp_valid1 !== 1'b1 || rsp_result1 !== 8'h02 || rsp_zero1 !== 1'b0) begin
      errors++; $display("FAIL lat1_rsp: got %b/%h/%b want 1/02/0", rsp_valid1, rsp_result1, rsp_zero1);
    end
    @(negedge clk);  // cycle 6
    checks++; if (rsp_valid1 !== 1'b0 || req_ready1 !== 1'b1) begin errors++; $display("FAIL lat1_done: got %b/%b want 0/1", rsp_valid1, req_ready1); end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; rsp_ready = 1'b0; req_a = 8'h00; req_b = 8'h00; req_op = 3'd0; out_bus = 8'h00;
    req_valid1 = 1'b0; rsp_ready1 = 1'b0; req_a1 = 8'h00; req_b1 = 8'h00; req_op1 = 3'd0; out_bus1 = 8'h00;
    test_reset();
    test_frame(8'h3C, 8'h05, OP_ADD, 8'h41, 1'b0);
    test_frame(8'h00, 8'h01, OP_SUB, 8'hFF, 1'b0);
    test_frame(8'hAA, 8'hAA, OP_XOR, 8'h00, 1'b1);
    test_back_to_back();
    test_stall();
    test_reset_in_wait();
    test_lat1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
